out_mem_streamer: RTL
=====================

OUT_MEM_STREAMER -- requirements
Module: out_mem_streamer

Interface
REQ-001 SHALL have parameter AW, default 12, meaning address width of the output image memory (2^AW bytes).
REQ-002 SHALL have port clk_50 input 1: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst input 1: reset, asynchronous and active-high.
REQ-004 SHALL have port start input 1: single-cycle request to stream the current output image.
REQ-005 SHALL have port out_w input 16: output width in pixels, sampled on an accepted start.
REQ-006 SHALL have port out_h input 16: output height in pixels, sampled on an accepted start.
REQ-007 SHALL have port mem_raddr output AW: read address into the output image memory.
REQ-008 SHALL have port mem_rdata input 8: memory read data, valid one cycle after mem_raddr is presented.
REQ-009 SHALL have port tx_data output 8: streamed byte.
REQ-010 SHALL have port tx_valid output 1: tx_data holds a byte for the sink.
REQ-011 SHALL have port tx_ready input 1: sink accepts the byte; a transfer occurs on a rising edge with tx_valid=1 and tx_ready=1.
REQ-012 SHALL have port busy output 1: high in every state except IDLE.
REQ-013 SHALL have port done output 1: one-cycle pulse at end of stream.
REQ-014 SHALL have port err_oversize output 1: sticky flag, out_w*out_h exceeds 2^AW.
REQ-015 SHALL have port byte_count output 32: number of transfers in the current or last stream.

Function
REQ-016 SHALL implement states IDLE, HDR, RD, WAIT, SEND, DONE.
REQ-017 SHALL accept start only in IDLE; start in any other state is ignored with no side effect.
REQ-018 On accepted start: latch out_w and out_h, compute total = out_w*out_h as a 32-bit unsigned product, clear byte_count, set pixel index idx=0, set err_oversize = (total > 2^AW), enter HDR.
REQ-019 HDR SHALL emit 4 bytes in order out_w[15:8], out_w[7:0], out_h[15:8], out_h[7:0], with tx_valid=1 from the first HDR cycle.
REQ-020 After the 4th header transfer: if total=0, go to DONE; otherwise go to RD.
REQ-021 SHALL hold mem_raddr = idx[AW-1:0] at all times.
REQ-022 RD SHALL last 1 cycle, then WAIT.
REQ-023 WAIT SHALL last 1 cycle; at its end, load tx_data with mem_rdata if idx < 2^AW, else with 0x00, and enter SEND.
REQ-024 SEND SHALL assert tx_valid and hold tx_data stable until a transfer occurs.
REQ-025 On a transfer in SEND: increment idx; if idx+1 = total, go to DONE; otherwise go to RD.
REQ-026 Minimum pixel cadence SHALL be 3 cycles per byte (RD, WAIT, SEND) with tx_ready held at 1.
REQ-027 tx_valid SHALL never deassert before its transfer, and SHALL be 0 in IDLE, RD, WAIT and DONE.
REQ-028 byte_count SHALL increment by 1 on every transfer (header and pixel) and hold its value after DONE until the next accepted start.
REQ-029 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-030 Pixel order SHALL be row-major with address = idx, giving y*out_w + x.
REQ-031 tx_ready while tx_valid=0 SHALL be ignored.

Reset
REQ-032 While rst=1, the block SHALL force state IDLE, tx_valid=0, tx_data=0x00, mem_raddr=0, busy=0, done=0, err_oversize=0, byte_count=0, idx=0 immediately, with no dependence on a clock edge.
REQ-033 Reset during any state SHALL abort the stream with no further transfers; the next start after release begins a fresh stream starting with the header.

Verification
REQ-034 Basic: out_w=8, out_h=8, mem[i]=i, tx_ready=1 -> bytes 00 08 00 08 then 00..3F, byte_count=68, one done pulse, err_oversize=0.
REQ-035 Empty: out_w=0, out_h=5 -> 4 header bytes 00 00 00 05, no memory reads, done pulse, byte_count=4.
REQ-036 Backpressure: 4x2 image, tx_ready toggled pseudo-randomly -> tx_data stable across every stall, 12 transfers in correct order, no duplicated or dropped bytes.
REQ-037 Oversize: AW=12, out_w=100, out_h=100 -> err_oversize=1, 10004 transfers, pixels with idx >= 4096 equal 0x00, done pulse.
REQ-038 Ignored start / reset: a start pulse mid-stream leaves the byte sequence unchanged; rst asserted after 10 pixel transfers -> tx_valid=0 and busy=0 immediately; a later start streams a full header plus image.

Source files
------------

// File: rtl/out_mem_streamer.sv
// out_mem_streamer: streams a 4-byte size header (width, height, big-endian)
// followed by the row-major pixels of the output image memory over a
// valid/ready byte interface. Pixels beyond the memory range read as 0x00.
module out_mem_streamer #(
   parameter int AW = 12
) (
   input  logic          clk_50,
   input  logic          rst,
   input  logic          start,
   input  logic [15:0]   out_w,
   input  logic [15:0]   out_h,
   output logic [AW-1:0] mem_raddr,
   input  logic [7:0]    mem_rdata,
   output logic [7:0]    tx_data,
   output logic          tx_valid,
   input  logic          tx_ready,
   output logic          busy,
   output logic          done,
   output logic          err_oversize,
   output logic [31:0]   byte_count
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      RD   = 3'd2,
      WAIT = 3'd3,
      SEND = 3'd4,
      DONE = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] w_q, w_d;
   logic [15:0] h_q, h_d;
   logic [31:0] total_q, total_d;
   logic [31:0] idx_q, idx_d;
   logic [1:0]  hcnt_q, hcnt_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_valid_q, tx_valid_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [31:0] byte_count_q, byte_count_d;
   logic        xfer_s;

   // Header byte selector: width high, width low, height high, height low.
   function automatic logic [7:0] hdr_byte(input logic [15:0] w, input logic [15:0] h,
                                           input logic [1:0] sel);
      logic [7:0] b;
      case (sel)
         2'd0:    b = w[15:8];
         2'd1:    b = w[7:0];
         2'd2:    b = h[15:8];
         2'd3:    b = h[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // True when a pixel index addresses real memory (idx < 2^AW).
   function automatic logic idx_in_range(input logic [31:0] idx);
      return ({1'b0, idx} < (33'd1 << AW));
   endfunction

   // True when the image holds more pixels than the memory (total > 2^AW).
   function automatic logic too_big(input logic [31:0] total);
      return ({1'b0, total} > (33'd1 << AW));
   endfunction

   assign xfer_s       = tx_valid_q & tx_ready;
   assign mem_raddr    = idx_q[AW-1:0];
   assign tx_data      = tx_data_q;
   assign tx_valid     = tx_valid_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err_oversize = err_q;
   assign byte_count   = byte_count_q;

   // Next-state and datapath computation; outputs are derived from the next state so they register in step with it.
   always_comb begin
      state_d      = state_q;
      w_d          = w_q;
      h_d          = h_q;
      total_d      = total_q;
      idx_d        = idx_q;
      hcnt_d       = hcnt_q;
      tx_data_d    = tx_data_q;
      err_d        = err_q;
      byte_count_d = byte_count_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               w_d          = out_w;
               h_d          = out_h;
               total_d      = {16'd0, out_w} * {16'd0, out_h};
               byte_count_d = 32'd0;
               idx_d        = 32'd0;
               hcnt_d       = 2'd0;
               err_d        = too_big(total_d);
               tx_data_d    = out_w[15:8];
               state_d      = HDR;
            end else begin
               state_d = IDLE;
            end
         end
         HDR: begin
            if (xfer_s) begin
               byte_count_d = byte_count_q + 32'd1;
               hcnt_d       = hcnt_q + 2'd1;
               if (hcnt_q == 2'd3) begin
                  state_d = (total_q == 32'd0) ? DONE : RD;
               end else begin
                  tx_data_d = hdr_byte(w_q, h_q, hcnt_q + 2'd1);
               end
            end else begin
               state_d = HDR;
            end
         end
         RD: begin
            state_d = WAIT;
         end
         WAIT: begin
            tx_data_d = idx_in_range(idx_q) ? mem_rdata : 8'h00;
            state_d   = SEND;
         end
         SEND: begin
            if (xfer_s) begin
               byte_count_d = byte_count_q + 32'd1;
               idx_d        = idx_q + 32'd1;
               state_d      = ((idx_q + 32'd1) == total_q) ? DONE : RD;
            end else begin
               state_d = SEND;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      tx_valid_d = (state_d == HDR) || (state_d == SEND);
      busy_d     = (state_d != IDLE);
      done_d     = (state_d == DONE);
   end

   // State and registered outputs, cleared immediately by reset.
   always_ff @(posedge clk_50 or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         w_q          <= 16'd0;
         h_q          <= 16'd0;
         total_q      <= 32'd0;
         idx_q        <= 32'd0;
         hcnt_q       <= 2'd0;
         tx_data_q    <= 8'h00;
         tx_valid_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         byte_count_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         w_q          <= w_d;
         h_q          <= h_d;
         total_q      <= total_d;
         idx_q        <= idx_d;
         hcnt_q       <= hcnt_d;
         tx_data_q    <= tx_data_d;
         tx_valid_q   <= tx_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         byte_count_q <= byte_count_d;
      end
   end

endmodule
